// File: rtl/idli_fetch_asm_m.sv
// idli_fetch_asm_m: packs SQI beats into words, tags each one as an instruction or an immediate, and queues it for the backend.
// `define IDLI_FAS_BYPASS_EN to hand a word to the outputs in the same cycle its last beat arrives, when the FIFO is empty.
module idli_fetch_asm_m #(
    parameter int LANE_W = 4,
    parameter int WORD_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic                       i_fas_gck,
    input  logic                       i_fas_rst,
    input  logic [LANE_W-1:0]          i_fas_lane,
    input  logic                       i_fas_lane_vld,
    output logic                       o_fas_lane_rdy,
    input  logic                       i_fas_flush,
    output logic [WORD_W-1:0]          o_fas_word,
    output logic                       o_fas_imm,
    output logic                       o_fas_vld,
    input  logic                       i_fas_rdy,
    output logic [$clog2(DEPTH+1)-1:0] o_fas_cnt
);
    localparam int BEATS = WORD_W / LANE_W;
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [2:0] GREG_PC = 3'b111;

    typedef enum logic {EXPECT_INSTR, EXPECT_IMM} state_t;

    state_t            state_q, state_d;
    logic [BW-1:0]     beat_q, beat_d;
    logic [WORD_W-1:0] sr_q, sr_d;
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WORD_W:0]   mem_q [DEPTH];
    logic [WORD_W-1:0] new_word;
    logic              new_imm, acc, last, byp, push, pop, head_vld;

    always_comb begin
        head_vld = cnt_q != '0;
        o_fas_lane_rdy = (beat_q != '0) | (cnt_q < CNT_FULL);
        new_word = (sr_q << LANE_W) | WORD_W'(i_fas_lane);
        new_imm = state_q == EXPECT_IMM;
        acc = i_fas_lane_vld & o_fas_lane_rdy & ~i_fas_flush;
        last = acc & (beat_q == BEAT_LAST);
`ifdef IDLI_FAS_BYPASS_EN
        byp = last & ~head_vld;
`else
        byp = 1'b0;
`endif
        // A bypassed word taken by the backend never enters the FIFO.
        push = last & ~(byp & i_fas_rdy);
        pop = head_vld & i_fas_rdy & ~i_fas_flush;
        o_fas_vld = head_vld | byp;
        o_fas_word = head_vld ? mem_q[rp_q][WORD_W-1:0] : (byp ? new_word : '0);
        o_fas_imm = head_vld ? mem_q[rp_q][WORD_W] : (byp & new_imm);
        o_fas_cnt = cnt_q;
        beat_d = (i_fas_flush | last) ? '0 : (acc ? beat_q + 1'b1 : beat_q);
        sr_d = acc ? new_word : sr_q;
        state_d = i_fas_flush ? EXPECT_INSTR :
                  ~last ? state_q :
                  (state_q == EXPECT_INSTR && new_word[2:0] == GREG_PC) ? EXPECT_IMM : EXPECT_INSTR;
        wp_d = i_fas_flush ? '0 : wp_q + PW'(push);
        rp_d = i_fas_flush ? '0 : rp_q + PW'(pop);
        cnt_d = i_fas_flush ? '0 : cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge i_fas_gck) begin
        if (i_fas_rst) begin
            state_q <= EXPECT_INSTR;
            beat_q  <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge i_fas_gck) begin
        sr_q <= sr_d;
        if (push) mem_q[wp_q] <= {new_imm, new_word};
    end
endmodule

// File: tb/tb_idli_fetch_asm_m.sv
// tb_idli_fetch_asm_m: directed and randomized checks of idli_fetch_asm_m against a queue-based word model.
module tb_idli_fetch_asm_m;
    logic        clk = 1'b0, rst = 1'b1;
    logic [3:0]  lane = '0;
    logic        lane_vld = 1'b0, lane_rdy, flush = 1'b0, vld, imm, rdy = 1'b0;
    logic [15:0] word;
    logic [1:0]  cnt;
    logic        s_lane = 1'b0, s_vld = 1'b0, s_lrdy, s_flush = 1'b0, s_imm, s_ovld, s_rdy = 1'b0;
    logic [15:0] s_word;
    logic [1:0]  s_cnt;
    int          total = 0, bad = 0;
    logic [16:0] q[$];
    int          nb = 0;
    int unsigned pw = 0;
    bit          ex = 1'b0, acc = 1'b0;
    logic [20:0] got, exp;

    always #5 clk = ~clk;

    idli_fetch_asm_m dut (
        .i_fas_gck(clk), .i_fas_rst(rst), .i_fas_lane(lane), .i_fas_lane_vld(lane_vld),
        .o_fas_lane_rdy(lane_rdy), .i_fas_flush(flush), .o_fas_word(word), .o_fas_imm(imm),
        .o_fas_vld(vld), .i_fas_rdy(rdy), .o_fas_cnt(cnt)
    );

    idli_fetch_asm_m #(.LANE_W(1)) dut1 (
        .i_fas_gck(clk), .i_fas_rst(rst), .i_fas_lane(s_lane), .i_fas_lane_vld(s_vld),
        .o_fas_lane_rdy(s_lrdy), .i_fas_flush(s_flush), .o_fas_word(s_word), .o_fas_imm(s_imm),
        .o_fas_vld(s_ovld), .i_fas_rdy(s_rdy), .o_fas_cnt(s_cnt)
    );

    function automatic logic [20:0] model_out();
        logic [16:0] h;
        h = q.size() != 0 ? q[0] : 17'h0;
        return {nb != 0 || q.size() < 2, q.size() != 0, h[16], 2'(q.size()), h[15:0]};
    endfunction

    task automatic drive(input logic v, input logic [3:0] l, input logic r, input logic f);
        bit lr;
        lane_vld = v; lane = l; rdy = r; flush = f;
        lr = nb != 0 || q.size() < 2;
        acc = 1'b0;
        @(posedge clk);
        if (rst || f) begin
            q.delete(); nb = 0; pw = 0; ex = 1'b0;
        end else begin
            if (q.size() != 0 && r) void'(q.pop_front());
            if (v && lr) begin
                acc = 1'b1; pw = pw * 16 + l; nb++;
                if (nb == 4) begin
                    q.push_back({ex, pw[15:0]});
                    ex = ex ? 1'b0 : (pw % 8 == 7);
                    nb = 0; pw = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic send_word(input logic [15:0] w, input logic r);
        for (int k = 0; k < 4; k++) begin
            int n = 0;
            do begin drive(1'b1, w[15-4*k -: 4], r, 1'b0); n++; end while (!acc && n < 20);
            if (!acc) begin total++; bad++; $display("FAIL send_word timeout beat=%0d", k); end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 4'($urandom), 1'b1, 1'b0);
        drive(1'b1, 4'($urandom), 1'b0, 1'b0);
        got = {lane_rdy, vld, imm, cnt, word}; exp = 21'h100000;
        total++; if (got !== exp) begin bad++; $display("FAIL reset got=%h exp=%h", got, exp); end
        total++; if ({s_lrdy, s_ovld, s_imm, s_cnt, s_word} !== 21'h100000) begin
            bad++; $display("FAIL reset_serial got=%h exp=%h", {s_lrdy, s_ovld, s_imm, s_cnt, s_word}, 21'h100000);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [3:0] b [4] = '{4'hA, 4'h1, 4'h2, 4'h3};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, b[k], 1'b1, 1'b0);
            got = {lane_rdy, vld, imm, cnt, word}; exp = model_out();
            total++; if (got !== exp) begin bad++; $display("FAIL basic k=%0d got=%h exp=%h", k, got, exp); end
        end
        total++; if ({vld, imm, word} !== {2'b10, 16'hA123}) begin
            bad++; $display("FAIL basic_word got=%h exp=%h", {vld, imm, word}, {2'b10, 16'hA123});
        end
        drive(1'b0, 4'h0, 1'b1, 1'b0);
        got = {lane_rdy, vld, imm, cnt, word}; exp = model_out();
        total++; if (got !== exp) begin bad++; $display("FAIL basic_pop got=%h exp=%h", got, exp); end
    endtask

    task automatic test_imm();
        logic [16:0] want [6] = '{{1'b0, 16'h1237}, {1'b1, 16'hBEEF}, {1'b0, 16'h0007},
                                  {1'b1, 16'h1111}, {1'b0, 16'h2222}, {1'b0, 16'h3333}};
        for (int k = 0; k < 6; k += 2) begin
            send_word(want[k][15:0], 1'b0);
            send_word(want[k+1][15:0], 1'b0);
            for (int j = 0; j < 2; j++) begin
                got = {lane_rdy, vld, imm, cnt, word}; exp = model_out();
                total++; if (got !== exp) begin bad++; $display("FAIL imm k=%0d j=%0d got=%h exp=%h", k, j, got, exp); end
                total++; if ({imm, word} !== want[k+j]) begin
                    bad++; $display("FAIL imm_tag k=%0d j=%0d got=%h exp=%h", k, j, {imm, word}, want[k+j]);
                end
                drive(1'b0, 4'h0, 1'b1, 1'b0);
            end
        end
    endtask

    task automatic test_full();
        logic [15:0] w [3];
        for (int k = 0; k < 3; k++) w[k] = 16'($urandom);
        send_word(w[0], 1'b0);
        send_word(w[1], 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, w[2][15:12], k == 3, 1'b0);
            got = {lane_rdy, vld, imm, cnt, word}; exp = model_out();
            total++; if (got !== exp) begin bad++; $display("FAIL full k=%0d got=%h exp=%h", k, got, exp); end
        end
        total++; if ({lane_rdy, cnt} !== 3'b101) begin bad++; $display("FAIL full_rdy got=%b exp=101", {lane_rdy, cnt}); end
        send_word(w[2], 1'b0);
        for (int k = 1; k < 3; k++) begin
            total++; if (word !== w[k]) begin bad++; $display("FAIL full_order k=%0d got=%h exp=%h", k, word, w[k]); end
            drive(1'b0, 4'h0, 1'b1, 1'b0);
        end
        total++; if ({vld, cnt} !== 3'b000) begin bad++; $display("FAIL full_drain got=%b exp=000", {vld, cnt}); end
    endtask

    task automatic test_flush();
        logic [15:0] w;
        w = 16'($urandom);
        send_word(16'h0007, 1'b0);
        drive(1'b1, 4'h5, 1'b0, 1'b0);
        drive(1'b1, 4'h6, 1'b0, 1'b0);
        drive(1'b1, 4'h7, 1'b1, 1'b1);
        got = {lane_rdy, vld, imm, cnt, word}; exp = 21'h100000;
        total++; if (got !== exp) begin bad++; $display("FAIL flush got=%h exp=%h", got, exp); end
        send_word(w, 1'b0);
        total++; if ({vld, imm, cnt, word} !== {2'b10, 2'd1, w}) begin
            bad++; $display("FAIL flush_fresh got=%h exp=%h", {vld, imm, cnt, word}, {2'b10, 2'd1, w});
        end
        drive(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] wa, wb;
        wa = 16'($urandom); wb = 16'($urandom);
        send_word(wa, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, wb[15-4*k -: 4], 1'b0, 1'b0);
        drive(1'b1, wb[3:0], 1'b1, 1'b0);
        got = {lane_rdy, vld, imm, cnt, word}; exp = model_out();
        total++; if (got !== exp) begin bad++; $display("FAIL b2b got=%h exp=%h", got, exp); end
        total++; if ({cnt, word} !== {2'd1, wb}) begin bad++; $display("FAIL b2b_head got=%h exp=%h", {cnt, word}, {2'd1, wb}); end
        drive(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        logic [15:0] w;
        w = 16'($urandom);
        send_word(16'h0007, 1'b0);
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b1, 4'h9, 1'b0, 1'b0);
        rst = 1'b0;
        got = {lane_rdy, vld, imm, cnt, word}; exp = 21'h100000;
        total++; if (got !== exp) begin bad++; $display("FAIL reset_mid got=%h exp=%h", got, exp); end
        send_word(w, 1'b0);
        total++; if ({vld, imm, word} !== {2'b10, w}) begin bad++; $display("FAIL reset_mid_word got=%h exp=%h", {vld, imm, word}, {2'b10, w}); end
        drive(1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(3) != 0, 4'($urandom), $urandom_range(2) != 0, $urandom_range(49) == 0);
            got = {lane_rdy, vld, imm, cnt, word}; exp = model_out();
            total++; if (got !== exp) begin bad++; $display("FAIL random k=%0d got=%h exp=%h", k, got, exp); end
        end
        drive(1'b0, 4'h0, 1'b0, 1'b1);
    endtask

    task automatic test_serial();
        logic [15:0] v;
        v = 16'h8001;
        for (int k = 0; k < 16; k++) begin
            s_vld = 1'b1; s_lane = v[15-k]; s_rdy = 1'b0;
            total++; if (s_lrdy !== 1'b1) begin bad++; $display("FAIL serial_rdy k=%0d got=%b exp=1", k, s_lrdy); end
            @(posedge clk); @(negedge clk);
            if (k < 15) begin
                total++; if (s_ovld !== 1'b0) begin bad++; $display("FAIL serial_early k=%0d got=%b exp=0", k, s_ovld); end
            end
        end
        s_vld = 1'b0;
        total++; if ({s_ovld, s_imm, s_cnt, s_word} !== {2'b10, 2'd1, 16'h8001}) begin
            bad++; $display("FAIL serial got=%h exp=%h", {s_ovld, s_imm, s_cnt, s_word}, {2'b10, 2'd1, 16'h8001});
        end
        s_rdy = 1'b1;
        @(posedge clk); @(negedge clk);
        s_rdy = 1'b0;
        total++; if ({s_ovld, s_cnt} !== 3'b000) begin bad++; $display("FAIL serial_pop got=%b exp=000", {s_ovld, s_cnt}); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_imm();
        test_full();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_serial();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
